// File: rtl/cache_pkg.sv
// Shared widths, request encoding and line layout for the set-associative cache.
package cache_pkg;

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int calc_off_w(input int words);
    return $clog2(words);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets, input int words);
    return addr_w - $clog2(sets) - $clog2(words);
  endfunction

  function automatic int calc_blk_w(input int words);
    return 32 * words;
  endfunction

  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  localparam int DEF_TAG_W = calc_tag_w(32, 64, 4);
  localparam int DEF_BLK_W = calc_blk_w(4);

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  // Logical view of one line in the default geometry.
  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [DEF_TAG_W-1:0] tag;
    logic [DEF_BLK_W-1:0] data;
  } cache_line_t;

endpackage

// File: rtl/cache_plru.sv
// Tree pseudo-LRU state for every set: victim for the addressed set and touch update.
module cache_plru
  import cache_pkg::*;
#(
  parameter  int WAYS  = 2,
  parameter  int SETS  = 64,
  localparam int IDX_W = calc_idx_w(SETS),
  localparam int WAY_W = calc_way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] index,
  input  logic             touch_en,
  input  logic [WAY_W-1:0] touch_way,
  output logic [WAY_W-1:0] victim_way
);

  generate
    if (WAYS == 1) begin : g_direct
      logic unused_plru;
      assign unused_plru = ^{clk, rst_n, index, touch_en, touch_way};
      assign victim_way  = '0;
    end else begin : g_tree
      localparam int LVL = $clog2(WAYS);
      // Heap-ordered nodes: node n lives in bit n-1; a 0 bit steers the victim left.
      logic [WAYS-2:0] plru_q [SETS];
      logic [WAYS-2:0] cur_bits;
      logic [WAYS-2:0] plru_d;

      assign cur_bits = plru_q[index];

      always_comb begin
        int node;
        node = 1;
        for (int l = 0; l < LVL; l++) begin
          node = 2 * node + int'(cur_bits[node-1]);
        end
        victim_way = WAY_W'(node - WAYS);
      end

      always_comb begin
        int node;
        int dir;
        plru_d = cur_bits;
        node   = 1;
        for (int l = 0; l < LVL; l++) begin
          dir              = int'(touch_way[LVL-1-l]);
          plru_d[node-1]   = (dir == 0);
          node             = 2 * node + dir;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (touch_en) begin
          plru_q[index] <= plru_d;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/cache_memory_sa.sv
// N-way set-associative cache tag/data store with PLRU replacement and victim export.
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_memory_sa
  import cache_pkg::*;
#(
  parameter  int WAYS          = 2,
  parameter  int SETS          = 64,
  parameter  int WORDS_PER_BLK = 4,
  parameter  int ADDR_W        = 32,
  localparam int IDX_W         = calc_idx_w(SETS),
  localparam int OFF_W         = calc_off_w(WORDS_PER_BLK),
  localparam int TAG_W         = calc_tag_w(ADDR_W, SETS, WORDS_PER_BLK),
  localparam int BLK_W         = calc_blk_w(WORDS_PER_BLK),
  localparam int WAY_W         = calc_way_w(WAYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [TAG_W-1:0] tag,
  input  logic [IDX_W-1:0] index,
  input  logic [OFF_W-1:0] blk_offset,
  input  logic             req_type,
  input  logic             read_en_cache,
  input  logic             write_en_cache,
  input  logic             ready_mem,
  input  logic [BLK_W-1:0] data_in_mem,
  input  logic [31:0]      data_in,
  output logic [BLK_W-1:0] dirty_block_out,
  output logic [TAG_W-1:0] dirty_tag_out,
  output logic             hit,
  output logic [31:0]      data_out,
`ifdef CACHE_STATS_EN
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count,
`endif
  output logic             dirty_bit
);

  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [BLK_W-1:0] data_mem [WAYS][SETS];
  logic [SETS-1:0]  valid_q  [WAYS];
  logic [SETS-1:0]  dirty_q  [WAYS];

  logic [WAYS-1:0]  hit_vec, inv_vec;
  logic             hit_any, inv_any, refill, lookup;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, victim_way, fill_way;
  logic             victim_valid;
  logic [BLK_W-1:0] base_blk, wr_blk;

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
      assign hit_vec[gi] = valid_q[gi][index] && (tag_mem[gi][index] == tag);
      assign inv_vec[gi] = ~valid_q[gi][index];
    end
  endgenerate

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (inv_vec[w]) inv_way = WAY_W'(w);
    end
  end

  assign hit_any      = |hit_vec;
  assign inv_any      = |inv_vec;
  assign refill       = write_en_cache & ready_mem;
  assign lookup       = (read_en_cache | write_en_cache) & ~refill;
  assign victim_way   = inv_any ? inv_way : plru_way;
  // A refill of a tag already resident reuses that way so no set holds duplicates.
  assign fill_way     = hit_any ? hit_way : victim_way;
  assign victim_valid = valid_q[victim_way][index];

  always_comb begin
    base_blk = refill ? data_in_mem : data_mem[hit_way][index];
    wr_blk   = base_blk;
    if (req_type == REQ_WRITE) wr_blk[blk_offset*32 +: 32] = data_in;
  end

  cache_plru #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk        (clk),
    .rst_n      (rst_n),
    .index      (index),
    .touch_en   (refill | (lookup & hit_any)),
    .touch_way  (refill ? fill_way : hit_way),
    .victim_way (plru_way)
  );

  always_ff @(posedge clk) begin
    if (refill) begin
      tag_mem[fill_way][index]  <= tag;
      data_mem[fill_way][index] <= wr_blk;
    end else if (lookup && hit_any && req_type == REQ_WRITE) begin
      data_mem[hit_way][index] <= wr_blk;
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      hit             <= 1'b0;
      data_out        <= '0;
      dirty_bit       <= 1'b0;
      dirty_block_out <= '0;
      dirty_tag_out   <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
`endif
    end else if (refill) begin
      valid_q[fill_way][index] <= 1'b1;
      dirty_q[fill_way][index] <= (req_type == REQ_WRITE);
    end else if (lookup) begin
      if (hit_any) begin
        hit <= 1'b1;
        if (req_type == REQ_WRITE) begin
          dirty_q[hit_way][index] <= 1'b1;
          dirty_bit               <= 1'b1;
        end else begin
          data_out  <= data_mem[hit_way][index][blk_offset*32 +: 32];
          dirty_bit <= dirty_q[hit_way][index];
        end
`ifdef CACHE_STATS_EN
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
`endif
      end else begin
        hit             <= 1'b0;
        dirty_bit       <= victim_valid & dirty_q[victim_way][index];
        dirty_block_out <= victim_valid ? data_mem[victim_way][index] : '0;
        dirty_tag_out   <= victim_valid ? tag_mem[victim_way][index] : '0;
`ifdef CACHE_STATS_EN
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cache_memory_sa.sv
// Directed vector bench for cache_memory_sa in its default 2-way, 64-set, 4-word geometry.
module tb_cache_memory_sa;
  import cache_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [23:0]   tag;
  logic [5:0]    index;
  logic [1:0]    blk_offset;
  logic          req_type;
  logic          read_en_cache;
  logic          write_en_cache;
  logic          ready_mem;
  logic [127:0]  data_in_mem;
  logic [31:0]   data_in;
  logic [127:0]  dirty_block_out;
  logic [23:0]   dirty_tag_out;
  logic          hit;
  logic [31:0]   data_out;
  logic          dirty_bit;
`ifdef CACHE_STATS_EN
  logic [31:0]   hit_count;
  logic [31:0]   miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cache_memory_sa dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tag             (tag),
    .index           (index),
    .blk_offset      (blk_offset),
    .req_type        (req_type),
    .read_en_cache   (read_en_cache),
    .write_en_cache  (write_en_cache),
    .ready_mem       (ready_mem),
    .data_in_mem     (data_in_mem),
    .data_in         (data_in),
    .dirty_block_out (dirty_block_out),
    .dirty_tag_out   (dirty_tag_out),
    .hit             (hit),
    .data_out        (data_out),
`ifdef CACHE_STATS_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
`endif
    .dirty_bit       (dirty_bit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [23:0]  tag;
    logic [5:0]   idx;
    logic [1:0]   off;
    logic         req, rd, wr, rdy;
    logic [127:0] dmem;
    logic [31:0]  din;
    logic         e_hit;
    logic [31:0]  e_data;
    logic         chk_data;
    logic         e_dirty;
    logic         chk_vic;
    logic [23:0]  e_vtag;
    logic [127:0] e_vblk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input string nm, input logic [23:0] t, input logic [5:0] ix,
                              input logic [1:0] of, input logic rq, input logic rd,
                              input logic wr, input logic rdy, input logic [127:0] dm,
                              input logic [31:0] di, input logic eh, input logic [31:0] ed,
                              input logic cd, input logic edb, input logic cv,
                              input logic [23:0] evt, input logic [127:0] evb);
    vec_t v;
    v.name = nm; v.tag = t; v.idx = ix; v.off = of; v.req = rq; v.rd = rd; v.wr = wr;
    v.rdy = rdy; v.dmem = dm; v.din = di; v.e_hit = eh; v.e_data = ed; v.chk_data = cd;
    v.e_dirty = edb; v.chk_vic = cv; v.e_vtag = evt; v.e_vblk = evb;
    return v;
  endfunction

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    ready_mem      = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    tag = v.tag; index = v.idx; blk_offset = v.off; req_type = v.req;
    read_en_cache = v.rd; write_en_cache = v.wr; ready_mem = v.rdy;
    data_in_mem = v.dmem; data_in = v.din;
    @(negedge clk);
    idle_inputs();
    check({v.name, ".hit"}, 128'(hit), 128'(v.e_hit));
    check({v.name, ".dirty_bit"}, 128'(dirty_bit), 128'(v.e_dirty));
    if (v.chk_data) check({v.name, ".data_out"}, 128'(data_out), 128'(v.e_data));
    if (v.chk_vic) begin
      check({v.name, ".dirty_tag_out"}, 128'(dirty_tag_out), 128'(v.e_vtag));
      check({v.name, ".dirty_block_out"}, dirty_block_out, v.e_vblk);
    end
    $display("[TB] %-12s tag=%06h idx=%0d off=%0d hit=%0b dirty=%0b data_out=%08h",
             v.name, v.tag, v.idx, v.off, hit, dirty_bit, data_out);
  endtask

  localparam logic [23:0]  TA = 24'h00ABCD;
  localparam logic [23:0]  TB = 24'h000001;
  localparam logic [23:0]  TC = 24'h000002;
  localparam logic [127:0] D1 = 128'hCAFEBABE_11112222_33334444_55556666;
  localparam logic [127:0] D1W = 128'hCAFEBABE_11112222_33334444_DEADBEEF;
  localparam logic [127:0] D2 = 128'hAAAA0001_AAAA0002_AAAA0003_AAAA0004;
  localparam logic [127:0] D3 = 128'h0C0C0003_0C0C0002_0C0C0001_0C0C0000;
  localparam logic [127:0] D4 = 128'h44440003_44440002_44440001_44440000;

  initial begin
    int exp_hits;
    int exp_miss;
    rst_n = 1'b0; tag = '0; index = '0; blk_offset = '0; req_type = REQ_READ;
    data_in_mem = '0; data_in = '0;
    idle_inputs();

    //           name         tag idx off req       rd wr rdy dmem din           hit data         cd dirty cv vtag vblk
    vecs.push_back(mk("rd_miss_A",  TA, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           0, 32'h0,        1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("fill_A",     TA, 5, 0, REQ_READ,  0, 1, 1, D1, '0,           0, 32'h0,        1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("rd_A3",      TA, 5, 3, REQ_READ,  1, 0, 0, '0, '0,           1, 32'hCAFEBABE, 1, 0, 0, 24'h0, '0));
    vecs.push_back(mk("rd_A0",      TA, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h55556666, 1, 0, 0, 24'h0, '0));
    vecs.push_back(mk("wr_A0",      TA, 5, 0, REQ_WRITE, 0, 1, 0, '0, 32'hDEADBEEF, 1, 32'h0,        0, 1, 0, 24'h0, '0));
    vecs.push_back(mk("rd_A0_wr",   TA, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           1, 32'hDEADBEEF, 1, 1, 0, 24'h0, '0));
    vecs.push_back(mk("rd_miss_B",  TB, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           0, 32'hDEADBEEF, 1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("fill_B",     TB, 5, 0, REQ_READ,  0, 1, 1, D2, '0,           0, 32'hDEADBEEF, 1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("rd_B1",      TB, 5, 1, REQ_READ,  1, 0, 0, '0, '0,           1, 32'hAAAA0003, 1, 0, 0, 24'h0, '0));
    vecs.push_back(mk("rd_miss_C",  TC, 5, 2, REQ_WRITE, 1, 0, 0, '0, '0,           0, 32'hAAAA0003, 1, 1, 1, TA, D1W));
    vecs.push_back(mk("fill_C_wr",  TC, 5, 2, REQ_WRITE, 1, 1, 1, D3, 32'h12345678, 0, 32'hAAAA0003, 1, 1, 1, TA, D1W));
    vecs.push_back(mk("rd_C2",      TC, 5, 2, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h12345678, 1, 1, 0, 24'h0, '0));
    vecs.push_back(mk("rd_C3",      TC, 5, 3, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h0C0C0003, 1, 1, 0, 24'h0, '0));
    vecs.push_back(mk("rd_C1",      TC, 5, 1, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h0C0C0001, 1, 1, 0, 24'h0, '0));
    vecs.push_back(mk("rd_miss_A2", TA, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           0, 32'h0C0C0001, 1, 0, 1, TB, D2));
    vecs.push_back(mk("rd_B0",      TB, 5, 0, REQ_READ,  1, 0, 0, '0, '0,           1, 32'hAAAA0004, 1, 0, 0, 24'h0, '0));
    vecs.push_back(mk("miss_idx6",  TA, 6, 0, REQ_READ,  1, 0, 0, '0, '0,           0, 32'hAAAA0004, 1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("refill_dupB",TB, 5, 0, REQ_READ,  1, 1, 1, D4, '0,           0, 32'hAAAA0004, 1, 0, 1, 24'h0, '0));
    vecs.push_back(mk("rd_B3_new",  TB, 5, 3, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h44440003, 1, 0, 0, 24'h0, '0));
    vecs.push_back(mk("rd_C2_kept", TC, 5, 2, REQ_READ,  1, 0, 0, '0, '0,           1, 32'h12345678, 1, 1, 0, 24'h0, '0));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.hit", 128'(hit), 128'(0));
    check("reset.data_out", 128'(data_out), 128'(0));
    check("reset.dirty_bit", 128'(dirty_bit), 128'(0));
    check("reset.dirty_block_out", dirty_block_out, '0);
    check("reset.dirty_tag_out", 128'(dirty_tag_out), 128'(0));

    exp_hits = 0;
    exp_miss = 0;
    foreach (vecs[i]) begin
      apply(vecs[i]);
      if ((vecs[i].rd || vecs[i].wr) && !(vecs[i].wr && vecs[i].rdy)) begin
        if (vecs[i].e_hit) exp_hits++;
        else exp_miss++;
      end
    end
`ifdef CACHE_STATS_EN
    check("stats.hit_count", 128'(hit_count), 128'(exp_hits));
    check("stats.miss_count", 128'(miss_count), 128'(exp_miss));
`endif

    // Reset pulse lands on a refill edge; the refill must be discarded.
    tag = 24'h000077; index = 6'd7; blk_offset = 2'd0; req_type = REQ_READ;
    data_in_mem = D4; write_en_cache = 1'b1; ready_mem = 1'b1;
    #3 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    check("rst_mid.hit", 128'(hit), 128'(0));
    check("rst_mid.data_out", 128'(data_out), 128'(0));
    check("rst_mid.dirty_bit", 128'(dirty_bit), 128'(0));
    $display("[TB] reset pulse during refill applied");
`ifdef CACHE_STATS_EN
    check("rst_mid.hit_count", 128'(hit_count), 128'(0));
    check("rst_mid.miss_count", 128'(miss_count), 128'(0));
`endif
    apply(mk("post_rst_A",  TA, 5, 0, REQ_READ, 1, 0, 0, '0, '0, 0, 32'h0, 1, 0, 1, 24'h0, '0));
    apply(mk("post_rst_C",  TC, 5, 2, REQ_READ, 1, 0, 0, '0, '0, 0, 32'h0, 1, 0, 1, 24'h0, '0));
    apply(mk("post_rst_77", 24'h000077, 7, 0, REQ_READ, 1, 0, 0, '0, '0, 0, 32'h0, 1, 0, 1, 24'h0, '0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_memory_sa.md
Name: cache_memory_sa

Overview:
- Parametrised N-way set-associative successor to the direct-mapped cache data/tag store.
- Same request-side signalling: lookup on read/write enable, refill from memory on write_en_cache with ready_mem, dirty-victim export.
- Adds associativity, tree pseudo-LRU replacement, an asynchronous active-low reset of all valid, dirty and LRU state, and victim-tag export for write-back address formation.
- Sits between the cache controller FSM and the memory interface.

Parameters:
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 64, sets per way; power of two. IDX_W = log2(SETS).
- WORDS_PER_BLK, 4, 32-bit words per block. OFF_W = log2(WORDS_PER_BLK); BLK_W = 32*WORDS_PER_BLK.
- ADDR_W, 32, word address width. TAG_W = ADDR_W - IDX_W - OFF_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- tag  in  TAG_W  request tag.
- index  in  IDX_W  request set.
- blk_offset  in  OFF_W  word select within block.
- req_type  in  1  0=read, 1=write.
- read_en_cache  in  1  read lookup strobe.
- write_en_cache  in  1  write lookup strobe, or refill strobe when ready_mem=1.
- ready_mem  in  1  data_in_mem valid; qualifies a refill.
- data_in_mem  in  BLK_W  refill block.
- data_in  in  32  write data.
- dirty_block_out  out  BLK_W  victim block data, registered.
- dirty_tag_out  out  TAG_W  victim tag, registered.
- hit  out  1  registered lookup result.
- data_out  out  32  registered read word.
- dirty_bit  out  1  hit: dirty bit of hit way; miss: dirty bit of victim.

Behaviour:
- Reset (async assert, sync release): all valid, dirty and PLRU bits cleared; hit, data_out, dirty_bit, dirty_block_out and dirty_tag_out = 0. Tag/data arrays are not reset.
- Cycle classes, evaluated each posedge:
  - refill = write_en_cache & ready_mem.
  - lookup = (read_en_cache | write_en_cache) & ~refill.
  - idle otherwise; all outputs hold.
- Lookup:
  - Compare tag against all valid ways of set[index]. Outputs update at the same edge, giving 1-cycle latency.
  - Read hit: hit=1; data_out=word[blk_offset] of hit way; dirty_bit=that way's dirty; PLRU touches hit way.
  - Write hit (req_type=1): data_in written to word[blk_offset]; dirty set; hit=1; dirty_bit=1; PLRU touch.
  - Miss: hit=0; no array/PLRU change; data_out holds.
    - Victim = lowest-numbered invalid way, else PLRU way.
    - dirty_bit = victim valid & dirty.
    - dirty_block_out and dirty_tag_out = victim data and tag. Both are zero-valued if victim invalid.
- Refill:
  - Victim recomputed from current index. The controller holds tag/index/blk_offset/req_type/data_in from miss to refill; no intervening lookup to the same set is allowed.
  - If tag already matches a valid way, that way is overwritten instead (no duplicate tags).
  - Line ← {valid=1, tag, data_in_mem}.
  - req_type=1: word[blk_offset] replaced by data_in and dirty=1. Else dirty=0.
  - PLRU touches the filled way. hit/data_out not updated; refill has priority over a simultaneous read_en_cache.
- PLRU: WAYS-1 bits per set (tree). On touch, node bits along the path point away from the touched way. WAYS=1: no PLRU state; victim is always way 0.
- Reset mid-operation: all lines become invalid; a pending refill is discarded.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - Each increments on a lookup hit/miss respectively and saturates at 32'hFFFF_FFFF. Refills are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cache_pkg: derived width functions/constants (IDX_W, OFF_W, TAG_W, BLK_W), a line struct typedef {valid, dirty, tag, data}, and the req_type encoding constants.
- Sub-module cache_plru: one per-set PLRU tree instance set. It provides touch-way update and victim-way output, parametrised by WAYS.

Test Plan:
1. After reset, read tag=24'h00ABCD, index=5, offset=0 → hit=0, dirty_bit=0, dirty_block_out=0, victim way 0.
2. Refill that address with data_in_mem=128'hCAFEBABE_11112222_33334444_55556666, req_type=0; then read offset=3 → hit=1, data_out=32'hCAFEBABE, dirty_bit=0.
3. Write hit offset=0 with data_in=32'hDEADBEEF → hit=1, dirty_bit=1; re-read offset=0 → 32'hDEADBEEF.
4. Fill way 1 of index 5 with tag 24'h000001; read tag 24'h000002 → victim is LRU way 0: dirty_bit=1, dirty_tag_out=24'h00ABCD, dirty_block_out has 32'hDEADBEEF in word 0.
5. Write-miss refill with req_type=1, offset=2, data_in=32'h12345678 → stored word2=32'h12345678, dirty=1, other words from data_in_mem.
6. Assert rst_n=0 for 3 ns mid-refill, release, re-read any filled address → hit=0; with CACHE_STATS_EN both counters read 0.
